// File: rtl/thermal_line_serializer.sv
`default_nettype none
// ============================================================================
// Module   : thermal_line_serializer
// Purpose  : two-bank print-line buffer with a serial shifter that drives
//            the print-head shift clock (CLKimpr) and dot data (DO).
// Revision : 1.0  initial release
// ============================================================================
module thermal_line_serializer #(
  parameter int LINE_BYTES = 48,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       CLKimpr,
  output logic       DO,
  output logic       busy,
  output logic       line_done
);

  localparam int PTR_W   = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [PTR_W-1:0] c_last_byte = PTR_W'(LINE_BYTES - 1);
  localparam logic [PTR_W-1:0] c_ptr_one   = PTR_W'(1);
  localparam logic [CNT_W-1:0] c_div_load  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] c_gap_load  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_LOW  = 3'd2,
    ST_HIGH = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  logic [7:0] mem [0:1][0:LINE_BYTES-1];

  state_t           state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] byte_idx_q, byte_idx_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       sr_q, sr_d;
  logic             clk_q, clk_d;
  logic             do_q, do_d;
  logic             line_done_q, line_done_d;

  logic       accept;
  logic [7:0] rd_byte;

  assign din_ready = ~full_q[wr_bank_q];
  assign accept    = din_valid & din_ready;
  assign rd_byte   = mem[rd_bank_q][byte_idx_q];

  assign CLKimpr   = clk_q;
  assign DO        = do_q;
  assign busy      = (state_q != ST_IDLE);
  assign line_done = line_done_q;

  // Line storage carries no reset; validity lives entirely in full_q.
  always_ff @(posedge CLK) begin
    if (accept) begin
      mem[wr_bank_q][wr_ptr_q] <= din;
    end
  end

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_ptr_d    = wr_ptr_q;
    byte_idx_d  = byte_idx_q;
    bit_idx_d   = bit_idx_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    clk_d       = clk_q;
    do_d        = do_q;
    line_done_d = 1'b0;

    if (accept) begin
      if (wr_ptr_q == c_last_byte) begin
        full_d[wr_bank_q] = 1'b1;
        wr_ptr_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + c_ptr_one;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d    = ST_LOAD;
          byte_idx_d = '0;
        end
      end
      ST_LOAD: begin
        sr_d      = rd_byte;
        bit_idx_d = 3'd7;
        do_d      = rd_byte[7];
        cnt_d     = c_div_load;
        state_d   = ST_LOW;
      end
      ST_LOW: begin
        if (cnt_q == '0) begin
          clk_d   = 1'b1;
          cnt_d   = c_div_load;
          state_d = ST_HIGH;
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      ST_HIGH: begin
        if (cnt_q == '0) begin
          clk_d = 1'b0;
          if (bit_idx_q != 3'd0) begin
            bit_idx_d = bit_idx_q - 3'd1;
            do_d      = sr_q[bit_idx_d];
            cnt_d     = c_div_load;
            state_d   = ST_LOW;
          end else if (byte_idx_q != c_last_byte) begin
            byte_idx_d = byte_idx_q + c_ptr_one;
            state_d    = ST_LOAD;
          end else begin
            // line_done must cover the final GAP cycle, even a single-cycle gap
            do_d        = 1'b0;
            cnt_d       = c_gap_load;
            line_done_d = (c_gap_load == '0);
            state_d     = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q - c_cnt_one;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = ~rd_bank_q;
          state_d           = ST_IDLE;
        end else begin
          cnt_d       = cnt_q - c_cnt_one;
          line_done_d = (cnt_d == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_ptr_q    <= '0;
      byte_idx_q  <= '0;
      bit_idx_q   <= 3'd0;
      cnt_q       <= '0;
      sr_q        <= 8'h00;
      clk_q       <= 1'b0;
      do_q        <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_ptr_q    <= wr_ptr_d;
      byte_idx_q  <= byte_idx_d;
      bit_idx_q   <= bit_idx_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      clk_q       <= clk_d;
      do_q        <= do_d;
      line_done_q <= line_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_thermal_line_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_thermal_line_serializer
// Purpose  : randomized self-checking bench for thermal_line_serializer
// Revision : 1.0  initial release
// ============================================================================
module tb_thermal_line_serializer;

  localparam int LINE_BYTES  = 48;
  localparam int LINE_BITS   = LINE_BYTES * 8;
  localparam int PERIOD      = LINE_BYTES * (1 + 16 * 4) + 16;
  localparam int PERIOD_FAST = LINE_BYTES * (1 + 16 * 1) + 1;

  logic clk, rst_n;
  logic [7:0] din, din_f;
  logic din_valid, din_ready, clkimpr, do_s, busy, line_done;
  logic din_valid_f, din_ready_f, clkimpr_f, do_f, busy_f, line_done_f;

  int n_checks, n_pass;

  typedef struct {
    int rises;
    int busy_cycles;
    int idle_before;
    int unstable;
    logic [LINE_BITS-1:0] bits;
  } line_rec_t;

  line_rec_t  lines[$];
  logic [7:0] send_q[$];
  logic [7:0] exp_q[$];

  thermal_line_serializer dut (
    .CLK(clk), .RST_N(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .CLKimpr(clkimpr), .DO(do_s), .busy(busy),
    .line_done(line_done)
  );

  thermal_line_serializer #(.LINE_BYTES(48), .CLK_DIV(1), .GAP_CYCLES(1)) dut_fast (
    .CLK(clk), .RST_N(rst_n), .din(din_f), .din_valid(din_valid_f),
    .din_ready(din_ready_f), .CLKimpr(clkimpr_f), .DO(do_f), .busy(busy_f),
    .line_done(line_done_f)
  );

  always #5 clk = ~clk;

  function automatic line_rec_t blank_rec();
    line_rec_t r;
    r.rises = 0; r.busy_cycles = 0; r.idle_before = 0; r.unstable = 0; r.bits = '0;
    return r;
  endfunction

  // Reference: bit n of a line is bit (7 - n%8) of byte n/8, first bit leftmost.
  function automatic logic [LINE_BITS-1:0] model_next_line();
    logic [7:0] b [LINE_BYTES];
    logic [LINE_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < LINE_BYTES; i++) b[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    for (int n = 0; n < LINE_BITS; n++) r[LINE_BITS-1-n] = b[n/8][7-(n%8)];
    return r;
  endfunction

  // Observes the main DUT and packs each shifted line into a record.
  int idle_run;
  initial begin
    line_rec_t acc;
    logic prev_clk, prev_do;
    acc = blank_rec(); idle_run = 0; prev_clk = 1'b0; prev_do = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc = blank_rec(); idle_run = 0; prev_clk = 1'b0; prev_do = 1'b0;
      end else begin
        if (busy) begin
          if (acc.busy_cycles == 0) acc.idle_before = idle_run;
          acc.busy_cycles++;
          idle_run = 0;
        end else begin
          idle_run++;
        end
        if (clkimpr && !prev_clk) begin
          acc.rises++;
          acc.bits = {acc.bits[LINE_BITS-2:0], do_s};
          if (do_s !== prev_do) acc.unstable++;
        end
        if (line_done) begin
          lines.push_back(acc);
          acc = blank_rec();
        end
        prev_clk = clkimpr; prev_do = do_s;
      end
    end
  end

  task automatic feed(input bit rand_valid, input int budget, output int stall_at,
                      output int ld_stalled, output int ready_back, output int timed_out);
    int k, acc_n;
    bit stalled, v;
    k = 0; acc_n = 0; stalled = 1'b0;
    stall_at = -1; ld_stalled = -1; ready_back = -1; timed_out = 0;
    while (send_q.size() > 0) begin
      @(negedge clk);
      if (k >= budget) begin timed_out = 1; break; end
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      din = send_q[0];
      din_valid = v;
      if (stalled && ld_stalled < 0 && line_done) ld_stalled = k;
      if (v && din_ready) begin
        if (stalled && ready_back < 0) ready_back = k;
        exp_q.push_back(send_q.pop_front());
        acc_n++;
      end else if (v && !stalled) begin
        stalled = 1'b1;
        stall_at = acc_n;
      end
      k++;
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_lines(input int n, input int budget, output int ok);
    int k;
    k = 0;
    while (lines.size() < n && k < budget) begin @(negedge clk); k++; end
    ok = (lines.size() >= n) ? 1 : 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din_valid = 1'b0; din_valid_f = 1'b0; din = 8'h00; din_f = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (clkimpr !== 1'b0) $display("FAIL reset_clkimpr: got %b want 0", clkimpr); else n_pass++;
    n_checks++; if (do_s !== 1'b0) $display("FAIL reset_do: got %b want 0", do_s); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (line_done !== 1'b0) $display("FAIL reset_line_done: got %b want 0", line_done); else n_pass++;
    n_checks++; if (din_ready !== 1'b1) $display("FAIL reset_din_ready: got %b want 1", din_ready); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (din_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL post_reset_idle: got ready=%b busy=%b want ready=1 busy=0", din_ready, busy); else n_pass++;
  endtask

  task automatic test_a5_line();
    int sa, ld, rb, to, ok;
    line_rec_t rec;
    logic [LINE_BITS-1:0] exp_bits, a5_bits;
    logic [7:0] a5;
    a5 = 8'hA5;
    a5_bits = {LINE_BYTES{a5}};
    for (int i = 0; i < LINE_BYTES; i++) send_q.push_back(a5);
    feed(1'b0, 500, sa, ld, rb, to);
    wait_lines(1, 2 * PERIOD, ok);
    rec = ok ? lines.pop_front() : blank_rec();
    exp_bits = model_next_line();
    n_checks++; if (ok == 0) $display("FAIL a5_line_done: got none want 1 line"); else n_pass++;
    n_checks++; if (rec.rises != LINE_BITS) $display("FAIL a5_rises: got %0d want %0d", rec.rises, LINE_BITS); else n_pass++;
    n_checks++; if (rec.busy_cycles != PERIOD) $display("FAIL a5_period: got %0d want %0d", rec.busy_cycles, PERIOD); else n_pass++;
    n_checks++; if (rec.bits !== a5_bits) $display("FAIL a5_pattern: got %h want %h", rec.bits, a5_bits); else n_pass++;
    n_checks++; if (rec.bits !== exp_bits) $display("FAIL a5_model: got %h want %h", rec.bits, exp_bits); else n_pass++;
    n_checks++; if (rec.unstable != 0) $display("FAIL a5_do_stable: got %0d unstable rises want 0", rec.unstable); else n_pass++;
  endtask

  task automatic test_ordered();
    int sa, ld, rb, to, ok;
    line_rec_t rec;
    logic [LINE_BITS-1:0] exp_bits;
    for (int i = 0; i < LINE_BYTES; i++) send_q.push_back(8'(i));
    feed(1'b0, 500, sa, ld, rb, to);
    wait_lines(1, 2 * PERIOD, ok);
    rec = ok ? lines.pop_front() : blank_rec();
    exp_bits = model_next_line();
    n_checks++; if (rec.bits !== exp_bits) $display("FAIL ordered_bits: got %h want %h", rec.bits, exp_bits); else n_pass++;
    n_checks++; if (rec.rises != LINE_BITS) $display("FAIL ordered_rises: got %0d want %0d", rec.rises, LINE_BITS); else n_pass++;
    n_checks++; if (rec.busy_cycles != PERIOD) $display("FAIL ordered_period: got %0d want %0d", rec.busy_cycles, PERIOD); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int sa, ld, rb, to, ok;
    line_rec_t rec;
    logic [LINE_BITS-1:0] exp_bits;
    for (int i = 0; i < 3 * LINE_BYTES; i++) send_q.push_back(8'($urandom));
    feed(1'b0, 3 * PERIOD, sa, ld, rb, to);
    n_checks++; if (to != 0) $display("FAIL b2b_feed_timeout: got timeout want none"); else n_pass++;
    n_checks++; if (sa != 2 * LINE_BYTES) $display("FAIL b2b_stall_point: got %0d want %0d", sa, 2 * LINE_BYTES); else n_pass++;
    n_checks++; if (ld < 0 || rb != ld + 1)
      $display("FAIL b2b_ready_return: got ready at %0d line_done at %0d want ready one cycle later", rb, ld); else n_pass++;
    wait_lines(3, 3 * PERIOD, ok);
    n_checks++; if (ok == 0) $display("FAIL b2b_lines: got %0d want 3", lines.size()); else n_pass++;
    for (int l = 0; l < 3; l++) begin
      rec = (lines.size() > 0) ? lines.pop_front() : blank_rec();
      exp_bits = model_next_line();
      n_checks++; if (rec.bits !== exp_bits) $display("FAIL b2b_bits[%0d]: got %h want %h", l, rec.bits, exp_bits); else n_pass++;
      n_checks++; if (rec.rises != LINE_BITS) $display("FAIL b2b_rises[%0d]: got %0d want %0d", l, rec.rises, LINE_BITS); else n_pass++;
      if (l > 0) begin
        n_checks++; if (rec.idle_before != 1) $display("FAIL b2b_idle[%0d]: got %0d want 1", l, rec.idle_before); else n_pass++;
      end
    end
  endtask

  task automatic test_random_valid();
    int sa, ld, rb, to, ok;
    line_rec_t rec;
    logic [LINE_BITS-1:0] exp_bits;
    for (int i = 0; i < 2 * LINE_BYTES; i++) send_q.push_back(8'($urandom));
    feed(1'b1, 3 * PERIOD, sa, ld, rb, to);
    wait_lines(2, 3 * PERIOD, ok);
    n_checks++; if (ok == 0) $display("FAIL rnd_lines: got %0d want 2", lines.size()); else n_pass++;
    for (int l = 0; l < 2; l++) begin
      rec = (lines.size() > 0) ? lines.pop_front() : blank_rec();
      exp_bits = model_next_line();
      n_checks++; if (rec.bits !== exp_bits) $display("FAIL rnd_bits[%0d]: got %h want %h", l, rec.bits, exp_bits); else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    int sa, ld, rb, to, ok, r, k;
    logic pc, pre_clk;
    line_rec_t rec;
    logic [LINE_BITS-1:0] exp_bits;
    for (int i = 0; i < LINE_BYTES; i++) send_q.push_back(8'($urandom));
    feed(1'b0, 500, sa, ld, rb, to);
    r = 0; k = 0; pc = 1'b0;
    while (k < 2 * PERIOD && !(r >= 20 * 8 + 4 && clkimpr)) begin
      @(negedge clk);
      if (clkimpr && !pc) r++;
      pc = clkimpr; k++;
    end
    #2;
    pre_clk = clkimpr;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pre_clk !== 1'b1 || r < 164) $display("FAIL mreset_setup: got clk=%b rises=%0d want clk=1 rises>=164", pre_clk, r); else n_pass++;
    n_checks++; if (clkimpr !== 1'b0) $display("FAIL mreset_clkimpr: got %b want 0", clkimpr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL mreset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (din_ready !== 1'b1) $display("FAIL mreset_din_ready: got %b want 1", din_ready); else n_pass++;
    repeat (2) @(negedge clk);
    exp_q.delete();
    lines.delete();
    rst_n = 1'b1;
    for (int i = 0; i < LINE_BYTES; i++) send_q.push_back(8'($urandom));
    feed(1'b0, 500, sa, ld, rb, to);
    wait_lines(1, 2 * PERIOD, ok);
    rec = ok ? lines.pop_front() : blank_rec();
    exp_bits = model_next_line();
    n_checks++; if (rec.bits !== exp_bits) $display("FAIL mreset_fresh_bits: got %h want %h", rec.bits, exp_bits); else n_pass++;
    n_checks++; if (rec.busy_cycles != PERIOD) $display("FAIL mreset_fresh_period: got %0d want %0d", rec.busy_cycles, PERIOD); else n_pass++;
  endtask

  task automatic test_fast();
    int nb, rises, hi_run, hi_min, hi_max, lo_run, lo1, lo2, ld_cnt, ld_at, k;
    logic pc;
    logic [LINE_BITS-1:0] bits, exp_bits;
    nb = 0; rises = 0; hi_run = 0; hi_min = 1000; hi_max = 0; lo_run = 0; lo1 = 0; lo2 = 0;
    ld_cnt = 0; ld_at = -1; bits = '0; pc = 1'b0;
    fork
      begin
        int sent, kk;
        logic [7:0] b;
        sent = 0; kk = 0;
        b = 8'($urandom);
        while (sent < LINE_BYTES && kk < 500) begin
          @(negedge clk);
          din_f = b; din_valid_f = 1'b1;
          if (din_ready_f) begin exp_q.push_back(b); sent++; b = 8'($urandom); end
          kk++;
        end
        @(negedge clk);
        din_valid_f = 1'b0;
      end
      begin
        k = 0;
        while (!busy_f && k < 500) begin @(negedge clk); k++; end
        while (busy_f && nb < 3 * PERIOD_FAST) begin
          nb++;
          if (clkimpr_f) begin
            if (!pc) begin
              rises++;
              bits = {bits[LINE_BITS-2:0], do_f};
              if (lo_run == 1) lo1++;
              else if (lo_run == 2) lo2++;
              hi_run = 0;
            end
            hi_run++;
          end else begin
            if (pc) begin
              if (hi_run < hi_min) hi_min = hi_run;
              if (hi_run > hi_max) hi_max = hi_run;
              lo_run = 0;
            end
            lo_run++;
          end
          if (line_done_f) begin ld_cnt++; ld_at = nb; end
          pc = clkimpr_f;
          @(negedge clk);
        end
      end
    join
    exp_bits = model_next_line();
    n_checks++; if (nb != PERIOD_FAST) $display("FAIL fast_period: got %0d want %0d", nb, PERIOD_FAST); else n_pass++;
    n_checks++; if (rises != LINE_BITS) $display("FAIL fast_rises: got %0d want %0d", rises, LINE_BITS); else n_pass++;
    n_checks++; if (hi_min != 1 || hi_max != 1) $display("FAIL fast_high_width: got min=%0d max=%0d want 1", hi_min, hi_max); else n_pass++;
    n_checks++; if (lo1 != LINE_BITS - LINE_BYTES || lo2 != LINE_BYTES)
      $display("FAIL fast_low_width: got one=%0d two=%0d want %0d/%0d", lo1, lo2, LINE_BITS - LINE_BYTES, LINE_BYTES); else n_pass++;
    n_checks++; if (ld_cnt != 1 || ld_at != PERIOD_FAST)
      $display("FAIL fast_line_done: got count=%0d at=%0d want 1 at %0d", ld_cnt, ld_at, PERIOD_FAST); else n_pass++;
    n_checks++; if (bits !== exp_bits) $display("FAIL fast_bits: got %h want %h", bits, exp_bits); else n_pass++;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0; n_checks = 0; n_pass = 0;
    din = 8'h00; din_valid = 1'b0; din_f = 8'h00; din_valid_f = 1'b0;
    test_reset();
    test_a5_line();
    test_ordered();
    test_back_to_back();
    test_random_valid();
    test_mid_reset();
    test_fast();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
